uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmit path between several byte producers: keyboard monitor, status reporter, debug dumper. Grants the UART write port to one requester for a whole message, terminated by a `last` byte, so messages never interleave. Paces writes against the UART `tx_full` flag. Sits between the producers and the `uart` `wr_uart`/`w_data` inputs.

## Interface
- `NREQ`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 1024: stall cycles before a forced release. Used only when `UART_ARB_TIMEOUT_EN` is defined.
- `clk`  input  1: system clock; all logic on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `req`  input  NREQ: per-requester byte request; held until acked.
- `data`  input  8*NREQ: byte k in `data[8k+7:8k]`; stable while `req[k]` is high.
- `last`  input  NREQ: byte k ends the message; stable with `data`.
- `tx_full`  input  1: UART TX FIFO full.
- `ack`  output  NREQ: one-cycle pulse; byte k was written.
- `wr_uart`  output  1: one-cycle UART write strobe.
- `w_data`  output  8: byte to the UART.
- `busy`  output  1: a message is in progress, i.e. not IDLE.
- `owner`  output  3: index of the current owner; 0 when idle.

## Operation
- Reset values:
  - `ack`=0, `wr_uart`=0, `w_data`=8'h00, `busy`=0, `owner`=0.
  - State IDLE; round-robin pointer = 0.
- IDLE:
  - If any `req` is high, pick the first requester at or after the pointer in cyclic order. Latch it as `owner` and go to LOCK.
  - If no `req` is high, stay in IDLE.
- LOCK, entered the cycle after the grant:
  - If `req[owner]` is high and `tx_full` is low, capture `data`/`last` of the owner and go to XFER.
  - Otherwise stay in LOCK.
  - Other requesters are ignored while in LOCK.
  - Deassertion of `req[owner]` mid-message does not release the lock.
- XFER, one cycle:
  - Drive `wr_uart`=1, `w_data`=captured byte, `ack[owner]`=1.
  - If the captured `last`=1: go to IDLE and set the pointer to `owner`+1 mod NREQ.
  - If the captured `last`=0: go back to LOCK.
- Requester contract: on seeing `ack[k]`, the requester either presents its next byte in the following cycle or drops `req`.
- Single-byte message = one byte with `last`=1.
- A request that arrives while another requester holds the lock waits. It is served no later than after NREQ-1 further messages.

## Timing
- Grant latency: `req` high in IDLE at cycle t → LOCK at t+1 → capture at t+1 if `tx_full` is low → `wr_uart`/`ack` at t+2.
- Sustained throughput: one byte per 2 cycles (LOCK, XFER). `tx_full` sampled in LOCK reflects the previous write, so no write is ever issued into a full FIFO.
- `tx_full` high in LOCK: no write, no ack. Resume on the first cycle `tx_full` is low.
- `ack` and `wr_uart` are always coincident and never high for two consecutive cycles.
- Back-to-back messages: XFER(last) → IDLE → LOCK. That is 1 cycle of re-arbitration.
- Asynchronous reset mid-message: all outputs clear immediately. A partially sent message is abandoned; already written bytes remain in the UART.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A stall counter in LOCK increments each cycle `req[owner]` is low and clears on capture.
  - At `TIMEOUT` the arbiter returns to IDLE, advances the pointer past `owner`, and asserts no ack.
  - Cycles stalled on `tx_full` do not count.
- `UART_ARB_TIMEOUT_EN` undefined: no counter; the lock is held until a `last` byte. `TIMEOUT` is unused.

## Structure
- Shared include/package `uart_arb_pkg`: state encodings IDLE/LOCK/XFER, `SP`=8'h20, default `NREQ`.
- Sub-module `rr_pick`: combinational round-robin picker. Takes `req` and the pointer; returns the grant index and a valid flag.
- The FSM, capture registers and optional stall counter are in `uart_tx_arbiter`.

## Test plan
- Single message: req0 sends 8'h41 with `last`=1 → `wr_uart` 2 cycles after `req`, `w_data`=8'h41, `ack[0]` one pulse, `busy` back to 0 next cycle.
- Non-interleave: req0 sends "AB " (last on 8'h20) while req1 requests 8'h31 mid-message → UART sees 41,42,20,31 in order.
- Fairness: req0 and req1 both continuously send 1-byte messages → alternating `owner` 0,1,0,1; pointer wraps at NREQ.
- Backpressure: `tx_full` held high 10 cycles during a message → no `wr_uart` or `ack` during those cycles; next byte written 1 cycle after `tx_full` falls.
- Reset: assert `reset` low during XFER of byte 2 of 3 → all outputs 0 immediately; after release, a new req1 message is granted first with pointer=0 behaviour.
- With `UART_ARB_TIMEOUT_EN`, `TIMEOUT`=16: owner drops `req` mid-message → IDLE after 16 stalled cycles; a waiting req1 is granted on the next cycle.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// the ASCII space terminator and the default requester count.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam logic [7:0] SP       = 8'h20;
  localparam int         NREQ_DEF = 2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// the pointer in cyclic order, plus a flag saying any requester was found.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_grant,
  output logic            o_valid
);

  // Rotating a doubled copy puts the pointer's requester at bit 0.
  logic [NREQ-1:0] w_rot;
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned k);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(k);
    if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
    return s[IW-1:0];
  endfunction

  // Scan from the far end so the nearest requester overrides.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_valid = 1'b1;
        o_grant = wrap_add(i_ptr, i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter for the UART write port; optional stall timeout
// is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  input  logic [NREQ-1:0]   last,
  input  logic              tx_full,
  output logic [NREQ-1:0]   ack,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic [2:0]        owner,
  output arb_state_e        dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_owner, r_ptr, w_grant, w_owner_inc;
  logic          w_valid, w_capture, w_own_req, w_stall_hit;
  logic [7:0]    r_byte;
  logic          r_last;
  logic [7:0]    w_bytes [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_bytes
    assign w_bytes[k] = data[8*k +: 8];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  assign w_own_req   = req[r_owner];
  assign w_owner_inc = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] r_stall;

  // Only an absent owner request counts; tx_full stalls leave the count alone.
  assign w_stall_hit = (r_state == LOCK) && !w_own_req && (r_stall == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (r_state != LOCK || w_capture) begin
      r_stall <= '0;
    end else if (!w_own_req) begin
      r_stall <= r_stall + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_stall_hit      = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: if (w_valid) w_state_nxt = LOCK;
      LOCK: begin
        if (w_own_req && !tx_full) begin
          w_capture   = 1'b1;
          w_state_nxt = XFER;
        end else if (w_stall_hit) begin
          w_state_nxt = IDLE;
        end
      end
      XFER:    w_state_nxt = r_last ? IDLE : LOCK;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= '0;
      r_ptr   <= '0;
      r_byte  <= 8'h00;
      r_last  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_valid) r_owner <= w_grant;
      if (w_capture) begin
        r_byte <= w_bytes[r_owner];
        r_last <= last[r_owner];
      end
      if ((r_state == XFER && r_last) || w_stall_hit) r_ptr <= w_owner_inc;
    end
  end

  // Outputs decode the state register so an async reset clears them at once.
  assign wr_uart   = (r_state == XFER);
  assign ack       = wr_uart ? (NREQ'(1) << r_owner) : '0;
  assign w_data    = wr_uart ? r_byte : 8'h00;
  assign busy      = (r_state != IDLE);
  assign owner     = busy ? 3'(r_owner) : 3'd0;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester drivers, a message-level
// round-robin model feeding an expected queue, and a write monitor.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 16;
  localparam int W  = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic [8*N-1:0]   data = '0;
  logic [N-1:0]     last = '0;
  logic             tx_full = 1'b0;
  logic [N-1:0]     ack;
  logic             wr_uart;
  logic [7:0]       w_data;
  logic             busy;
  logic [2:0]       owner;
  arb_state_e       dbg_state;

  uart_tx_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .last      (last),
    .tx_full   (tx_full),
    .ack       (ack),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .owner     (owner),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [8:0]  src_mem [N][256];
  int          src_wr [N];
  int          src_rd [N];
  int          mdl_rd [N];
  int          m_ptr = 0;
  logic        drv_en = 1'b1;
  logic        txf_rand = 1'b0;
  logic        txf_s = 1'b0;
  logic        prev_wr = 1'b0;
  int          nm, len;

  always @(posedge clk) txf_s <= tx_full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic add_byte(input int k, input logic [7:0] b, input logic l);
    src_mem[k][src_wr[k]] = {l, b};
    src_wr[k]++;
  endtask

  // Message-level model: every requester with pending messages is requesting
  // whenever the arbiter is idle, so service order is plain round robin.
  task automatic model_schedule();
    int k;
    bit found;
    logic [8:0] e;
    forever begin
      found = 0;
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && mdl_rd[(m_ptr + i) % N] < src_wr[(m_ptr + i) % N]) begin
          found = 1;
          k = (m_ptr + i) % N;
        end
      end
      if (!found) break;
      e = '0;
      while (mdl_rd[k] < src_wr[k] && !e[8]) begin
        e = src_mem[k][mdl_rd[k]];
        mdl_rd[k]++;
        exp_q.push_back({4'(k), e[7:0]});
      end
      if (!e[8]) break;
      m_ptr = (k + 1) % N;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_step();
    for (int k = 0; k < N; k++) begin
      if (ack[k]) src_rd[k]++;
      if (drv_en && src_rd[k] < src_wr[k]) begin
        req[k]          = 1'b1;
        data[8*k +: 8]  = src_mem[k][src_rd[k]][7:0];
        last[k]         = src_mem[k][src_rd[k]][8];
      end else begin
        req[k] = 1'b0;
      end
    end
    if (txf_rand) tx_full = ($urandom_range(0, 3) == 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_step();
    logic [W-1:0] e;
    if (reset && wr_uart) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %02h with nothing expected", w_data);
      end else begin
        e = exp_q.pop_front();
        check("w_data", 32'(w_data), 32'(e[7:0]));
        check("ack", 32'(ack), 32'(1) << e[11:8]);
        check("owner", 32'(owner), 32'(e[11:8]));
      end
      check("tx_full_at_capture", 32'(txf_s), 0);
      check("no_back_to_back", 32'(prev_wr), 0);
    end else if (reset) begin
      check("ack_without_write", 32'(ack), 0);
    end
    prev_wr = wr_uart;
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
    drive_step();
  end

  task automatic wait_write(input string name, input logic [7:0] b, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_uart && w_data == b) begin
        seen = 1;
        break;
      end
    end
    check(name, 32'(seen), 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    #1;
    check({"drain_", name}, exp_q.size(), 0);
    check({"idle_", name}, 32'(busy), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_uart", 32'(wr_uart), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_w_data", 32'(w_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;

    // Single-byte message and grant latency
    @(posedge clk); #1;
    add_byte(0, 8'h41, 1'b1);
    model_schedule();
    @(negedge clk);
    @(negedge clk); #1;
    check("lat_lock_busy", 32'(busy), 1);
    check("lat_lock_no_write", 32'(wr_uart), 0);
    @(negedge clk); #1;
    check("lat_write", 32'(wr_uart), 1);
    check("lat_ack", 32'(ack), 32'b01);
    @(negedge clk); #1;
    check("lat_idle", 32'(busy), 0);

    // Non-interleave: req1 arrives in the middle of req0's message
    @(posedge clk); #1;
    add_byte(0, 8'h41, 1'b0);
    add_byte(0, 8'h42, 1'b0);
    add_byte(0, SP, 1'b1);
    model_schedule();
    repeat (3) @(posedge clk);
    #1;
    add_byte(1, 8'h31, 1'b1);
    model_schedule();
    wait_drain("nonint", 100);

    // Fairness: both continuously sending single-byte messages
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      add_byte(0, 8'(8'h50 + i), 1'b1);
      add_byte(1, 8'(8'h60 + i), 1'b1);
    end
    model_schedule();
    wait_drain("fair", 200);

    // Backpressure: tx_full high for 10 cycles mid-message
    @(posedge clk); #1;
    add_byte(0, 8'h71, 1'b0);
    add_byte(0, 8'h72, 1'b0);
    add_byte(0, 8'h73, 1'b1);
    model_schedule();
    wait_write("bp_first", 8'h71, 20);
    #1 tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_hold_write", 32'(wr_uart), 0);
      check("bp_hold_ack", 32'(ack), 0);
    end
    tx_full = 1'b0;
    @(negedge clk); #1;
    check("bp_resume", 32'(wr_uart), 1);
    wait_drain("bp", 100);

    // Async reset during byte 2 of 3; pointer must return to 0
    @(posedge clk); #1;
    add_byte(0, 8'h81, 1'b0);
    add_byte(0, 8'h82, 1'b0);
    add_byte(0, 8'h83, 1'b1);
    model_schedule();
    wait_write("rst_mid", 8'h82, 20);
    #2;
    reset  = 1'b0;
    drv_en = 1'b0;
    #1;
    check("rstmid_wr_uart", 32'(wr_uart), 0);
    check("rstmid_ack", 32'(ack), 0);
    check("rstmid_w_data", 32'(w_data), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_owner", 32'(owner), 0);
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      src_rd[k] = src_wr[k];
      mdl_rd[k] = src_wr[k];
    end
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    drv_en = 1'b1;
    @(posedge clk); #1;
    add_byte(1, 8'h91, 1'b1);
    add_byte(0, 8'h92, 1'b1);
    model_schedule();
    wait_drain("post_reset", 100);

    // Randomized messages with random tx_full
    txf_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        nm = $urandom_range(1, 4);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            add_byte(k, 8'($urandom_range(0, 255)), b == len - 1);
        end
      end
      model_schedule();
      wait_drain("rand", 3000);
    end
    txf_rand = 1'b0;
    @(negedge clk); #1 tx_full = 1'b0;

`ifdef UART_ARB_TIMEOUT_EN
    // Owner abandons its message; lock released after TO stalled cycles
    @(posedge clk); #1;
    add_byte(0, 8'hA1, 1'b0);
    model_schedule();
    wait_write("to_first", 8'hA1, 20);
    #1;
    add_byte(1, 8'hB1, 1'b1);
    model_schedule();
    for (int i = 0; i < TO; i++) begin
      @(negedge clk); #1;
      check("to_held_busy", 32'(busy), 1);
      check("to_held_owner", 32'(owner), 0);
    end
    @(negedge clk); #1;
    check("to_released", 32'(busy), 0);
    check("to_no_ack", 32'(ack), 0);
    @(negedge clk); #1;
    check("to_regrant_busy", 32'(busy), 1);
    check("to_regrant_owner", 32'(owner), 1);
    wait_drain("timeout", 100);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
